// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encodings and default width
package serial_add_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand request and result handshake bundle
interface serial_add_ctrl_if import serial_add_ctrl_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, busy;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input in_ready, out_valid, sum, cout, ovf, busy);
  modport slave (input in_valid, a, b, cin, sub, out_ready,
                 output in_ready, out_valid, sum, cout, ovf, busy);
endinterface

// File: rtl/serial_add_ctrl_fa_lut_cell.sv
// fa_lut_cell: 1-bit full adder built from two 8-entry truth tables
module fa_lut_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  localparam logic [7:0] SUM_LUT = 8'h96;
  localparam logic [7:0] COUT_LUT = 8'hE8;
  logic [2:0] idx;
  assign idx = {a, b, cin};
  assign sum = SUM_LUT[idx];
  assign cout = COUT_LUT[idx];
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract, one LSB-first bit per clock
module serial_add_ctrl import serial_add_ctrl_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic clk,
  input  logic rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] ra, rb, rs;
  logic carry, rc, ro, cs, cc, last;
  fa_lut_cell u_fa (.a(ra[0]), .b(rb[0]), .cin(carry), .sum(cs), .cout(cc));
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign bus.in_ready = state == S_IDLE;
  assign bus.out_valid = state == S_DONE;
  assign bus.busy = state == S_RUN || state == S_DONE;
  assign bus.sum = rs;
  assign bus.cout = rc;
  assign bus.ovf = ro;
  always_comb begin
    nxt = S_IDLE;
    nxt = state == S_IDLE ? (bus.in_valid ? S_RUN : S_IDLE) :
          state == S_RUN  ? (last ? S_DONE : S_RUN) :
          state == S_DONE ? (bus.out_ready ? S_IDLE : S_DONE) : S_IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ra <= '0;
      rb <= '0;
      rs <= '0;
      carry <= 1'b0;
      rc <= 1'b0;
      ro <= 1'b0;
    end else if (state == S_IDLE && bus.in_valid) begin
      ra <= bus.a;
      rb <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub | bus.cin;
      cnt <= '0;
    end else if (state == S_RUN) begin
      rs <= {cs, rs[WIDTH-1:1]};
      ra <= ra >> 1;
      rb <= rb >> 1;
      carry <= cc;
      cnt <= cnt + 1'b1;
      if (last) begin
        rc <= cc;
        ro <= carry ^ cc;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the serial add/sub controller
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  serial_add_ctrl_if #(.WIDTH(8)) bus ();
  serial_add_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts);
    @(negedge clk);
    bus.a = ta;
    bus.b = tb;
    bus.cin = tc;
    bus.sub = ts;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.a = ~ta;
    bus.b = ~tb;
  endtask
  task automatic wait_done(input string tag);
    int lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, " latency"}, lat, 8);
  endtask
  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk({tag, " idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
  endtask
  task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                    input logic ts, input logic [7:0] es, input logic ec, input logic eo);
    start(ta, tb, tc, ts);
    wait_done(tag);
    chk({tag, " sum"}, bus.sum, es);
    chk({tag, " cout/ovf"}, {bus.cout, bus.ovf}, {ec, eo});
    release_result(tag);
  endtask
  initial begin
    logic [7:0] ra, rb, bb, es;
    logic rc, rs, ec, eo;
    logic [8:0] full;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset flags", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    chk("reset result", {bus.sum, bus.cout, bus.ovf}, 10'd0);
    rst = 1'b0;
    op("3c+05", 8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0);
    op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("ff+00+c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    op("7f+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op("05-07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    op("80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    start(8'h12, 8'h34, 1'b0, 1'b0);
    chk("run busy", {bus.busy, bus.in_ready}, 2'b10);
    wait_done("hold");
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 chk("hold state", {bus.out_valid, bus.in_ready, bus.busy}, 3'b101);
      chk("hold sum", bus.sum, 8'h46);
    end
    bus.in_valid = 1'b0;
    release_result("hold");
    start(8'h55, 8'h11, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    op("10+20", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      bb = rs ? ~rb : rb;
      full = {1'b0, ra} + {1'b0, bb} + {8'd0, rs | rc};
      es = full[7:0];
      ec = full[8];
      eo = (ra[7] == bb[7]) && (es[7] != ra[7]);
      op("rand", ra, rb, rc, rs, es, ec, eo);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
